dec_n_seq: RTL and testbench

- Parametrised, registered N-to-2^N one-hot decoder; next generation of the team's 2-to-4 gate-level decoder.
- Adds three sequential modes: latched hold, timed pulse and auto-scan.
- Drives chip-select, row-strobe and LED-scan lines from a control FSM.
- Output is registered, so no decode glitches reach the pins.

---
 rtl/dec_n_seq.sv | 124 ++++++++++++
 tb/tb_dec_n_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dec_n_seq.sv
// Registered N-to-2^N one-hot decoder with hold, timed-pulse and auto-scan modes.
// Define DEC_ACTIVE_LOW_EN to make y one-cold (active-low, all ones when inactive).
module dec_n_seq #(
  parameter int N         = 2,
  parameter int PULSE_LEN = 3,
  parameter int SCAN_DIV  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               load,
  input  logic [1:0]         mode,
  input  logic [N-1:0]       sel,
  output logic [0:(1<<N)-1]  y,
  output logic [N-1:0]       idx,
  output logic               busy
);

  localparam int OUT_W = 1 << N;

`ifdef DEC_ACTIVE_LOW_EN
  localparam logic [0:OUT_W-1] Y_IDLE = '1;
  localparam logic             Y_ACT  = 1'b0;
`else
  localparam logic [0:OUT_W-1] Y_IDLE = '0;
  localparam logic             Y_ACT  = 1'b1;
`endif

  // Counters start at 0 on entry, so the terminal value is LEN-1.
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_LEN - 1);
  localparam logic [7:0] SCAN_LAST  = 8'(SCAN_DIV - 1);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_PULSE = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    PULSE = 2'd2,
    SCAN  = 2'd3
  } state_t;

  state_t       state;
  logic [7:0]   cnt;
  logic         accept;
  logic [N-1:0] idx_next;

  function automatic logic [0:OUT_W-1] decode(input logic [N-1:0] code);
    logic [0:OUT_W-1] r;
    r       = Y_IDLE;
    r[code] = Y_ACT;
    return r;
  endfunction

  // A running pulse swallows commands; reserved mode 11 is never accepted.
  assign accept   = load && (state != PULSE) && (mode != 2'b11);
  assign idx_next = idx + N'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      y     <= Y_IDLE;
      idx   <= '0;
      busy  <= 1'b0;
      cnt   <= '0;
    end else if (!en) begin
      state <= IDLE;
      y     <= Y_IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      cnt <= '0;
      idx <= sel;
      y   <= decode(sel);
      case (mode)
        MODE_HOLD: begin
          state <= HOLD;
          busy  <= 1'b0;
        end
        MODE_PULSE: begin
          state <= PULSE;
          busy  <= 1'b1;
        end
        MODE_SCAN: begin
          state <= SCAN;
          busy  <= 1'b1;
        end
        default: begin
          state <= state;
        end
      endcase
    end else begin
      case (state)
        PULSE: begin
          if (cnt == PULSE_LAST) begin
            state <= IDLE;
            y     <= Y_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SCAN: begin
          if (cnt == SCAN_LAST) begin
            cnt <= '0;
            idx <= idx_next;
            y   <= decode(idx_next);
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

  // y is either fully inactive or has exactly one active line.
  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(y ^ Y_IDLE));

endmodule

// File: tb/tb_dec_n_seq.sv
// Directed bench for dec_n_seq (N=2, PULSE_LEN=3, SCAN_DIV=4): reset, hold,
// pulse, scan wrap/abort/restart, enable drop and reserved mode.
module tb_dec_n_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       load;
  logic [1:0] mode;
  logic [1:0] sel;
  logic [0:3] y;
  logic [1:0] idx;
  logic       busy;

  int checks;
  int errors;

  dec_n_seq #(.N(2), .PULSE_LEN(3), .SCAN_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .load  (load),
    .mode  (mode),
    .sel   (sel),
    .y     (y),
    .idx   (idx),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected y values below are written active-high, as printed y[0]..y[3].
  function automatic logic [3:0] pol(input logic [3:0] v);
`ifdef DEC_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives one cycle of inputs, then returns 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic e, input logic l, input logic [1:0] m,
                               input logic [1:0] s);
    en   = e;
    load = l;
    mode = m;
    sel  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [3:0] ey,
                          input logic [1:0] eidx, input logic ebusy);
    checkOutput({tag, ".y"},    32'(y),    32'(pol(ey)));
    checkOutput({tag, ".idx"},  32'(idx),  32'(eidx));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(ebusy));
  endtask

  initial begin
    logic [1:0] sidx;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    load   = 1'b0;
    mode   = 2'b00;
    sel    = 2'b00;
    #1;
    checkAll("reset", 4'b0000, 2'd0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Hold sel=2 and keep it for 20 cycles.
    applyStimulus(1'b1, 1'b1, 2'b00, 2'd2);
    checkAll("hold", 4'b0010, 2'd2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 2'b00, 2'd0);
      checkOutput("hold_keep", 32'(y), 32'(pol(4'b0010)));
    end

    // Asynchronous reset mid-cycle.
    #2 rst_n = 1'b0;
    #1;
    checkAll("async_reset", 4'b0000, 2'd0, 1'b0);
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'b00, 2'd0);
    checkAll("after_reset", 4'b0000, 2'd0, 1'b0);

    // Pulse sel=1 for three cycles; a load mid-pulse is dropped.
    applyStimulus(1'b1, 1'b1, 2'b01, 2'd1);
    checkAll("pulse1", 4'b0100, 2'd1, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'b01, 2'd3);
    checkAll("pulse2", 4'b0100, 2'd1, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b00, 2'd0);
    checkAll("pulse3", 4'b0100, 2'd1, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b00, 2'd0);
    checkAll("pulse_end", 4'b0000, 2'd1, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 2'd0);
    checkAll("pulse_idle", 4'b0000, 2'd1, 1'b0);

    // Scan from 3: wraps 3 -> 0 -> 1, four cycles per step.
    applyStimulus(1'b1, 1'b1, 2'b10, 2'd3);
    checkAll("scan_start", 4'b0001, 2'd3, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 1'b0, 2'b00, 2'd0);
      sidx = 2'(3 + i / 4);
      checkAll("scan_step", 4'b1000 >> sidx, sidx, 1'b1);
    end

    // Abort scan (currently at idx 1) with hold sel=0.
    applyStimulus(1'b1, 1'b1, 2'b00, 2'd0);
    checkAll("scan_abort", 4'b1000, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 2'b00, 2'd0);
    checkAll("abort_hold", 4'b1000, 2'd0, 1'b0);

    // Enable drop during HOLD with a simultaneous load.
    applyStimulus(1'b1, 1'b1, 2'b00, 2'd2);
    checkAll("hold2", 4'b0010, 2'd2, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b00, 2'd1);
    checkAll("en_drop_hold", 4'b0000, 2'd2, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 2'd0);
    checkAll("en_back_idle", 4'b0000, 2'd2, 1'b0);

    // Enable drop during SCAN with a simultaneous load.
    applyStimulus(1'b1, 1'b1, 2'b10, 2'd1);
    checkAll("scan2", 4'b0100, 2'd1, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b00, 2'd0);
    applyStimulus(1'b1, 1'b0, 2'b00, 2'd0);
    applyStimulus(1'b0, 1'b1, 2'b00, 2'd3);
    checkAll("en_drop_scan", 4'b0000, 2'd1, 1'b0);

    // Reserved mode 11 leaves HOLD untouched.
    applyStimulus(1'b1, 1'b1, 2'b00, 2'd3);
    checkAll("hold3", 4'b0001, 2'd3, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b11, 2'd0);
    checkAll("mode11", 4'b0001, 2'd3, 1'b0);

    // Re-issuing scan mid-step clears the step counter.
    applyStimulus(1'b1, 1'b1, 2'b10, 2'd0);
    checkAll("scan3", 4'b1000, 2'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'b00, 2'd0);
    applyStimulus(1'b1, 1'b0, 2'b00, 2'd0);
    applyStimulus(1'b1, 1'b0, 2'b00, 2'd0);
    applyStimulus(1'b1, 1'b1, 2'b10, 2'd2);
    checkAll("scan_restart", 4'b0010, 2'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 2'b00, 2'd0);
      checkOutput("restart_wait", 32'(y), 32'(pol(4'b0010)));
    end
    applyStimulus(1'b1, 1'b0, 2'b00, 2'd0);
    checkAll("restart_step", 4'b0001, 2'd3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
